// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: latches a byte and its parity, then paces load/shift
// strobes to an external TX shift register over start + 8 data + parity + stop bits.
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 868,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       tx_abort,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       sr_load,
    output logic       sr_shift,
    output logic [7:0] sr_din,
    output logic       parity_bit
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_TC = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0] LAST_SHIFT = 4'd9;

    typedef enum logic [2:0] {IDLE, LOAD, SEND, STOP, ABORT} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] baud_cnt_reg, baud_cnt_next;
    logic [3:0]    shift_cnt_reg, shift_cnt_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;
    logic          load_reg, load_next;
    logic          shift_reg, shift_next;
    logic [7:0]    din_reg, din_next;
    logic          parity_reg, parity_next;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            baud_cnt_reg  <= '0;
            shift_cnt_reg <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            load_reg      <= 1'b0;
            shift_reg     <= 1'b0;
            din_reg       <= 8'h00;
            parity_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            baud_cnt_reg  <= baud_cnt_next;
            shift_cnt_reg <= shift_cnt_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            load_reg      <= load_next;
            shift_reg     <= shift_next;
            din_reg       <= din_next;
            parity_reg    <= parity_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        baud_cnt_next  = baud_cnt_reg;
        shift_cnt_next = shift_cnt_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;
        load_next      = 1'b0;
        shift_next     = 1'b0;
        din_next       = din_reg;
        parity_next    = parity_reg;

        case (state_reg)
            IDLE: begin
                if (tx_start && !tx_abort) begin
                    din_next    = tx_data;
                    parity_next = (^tx_data) ^ PARITY_ODD;
                    state_next  = LOAD;
                end
            end
            LOAD: begin
                if (tx_abort) begin
                    state_next = ABORT;
                end else begin
                    load_next      = 1'b1;
                    busy_next      = 1'b1;
                    baud_cnt_next  = '0;
                    shift_cnt_next = '0;
                    state_next     = SEND;
                end
            end
            SEND: begin
                if (tx_abort) begin
                    state_next = ABORT;
                end else if (baud_cnt_reg == BAUD_TC) begin
                    baud_cnt_next = '0;
                    shift_next    = 1'b1;
                    if (shift_cnt_reg == LAST_SHIFT) begin
                        shift_cnt_next = '0;
                        state_next     = STOP;
                    end else begin
                        shift_cnt_next = shift_cnt_reg + 4'd1;
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg + 1'b1;
                end
            end
            STOP: begin
                if (tx_abort) begin
                    state_next = ABORT;
                end else if (baud_cnt_reg == BAUD_TC) begin
                    baud_cnt_next = '0;
                    done_next     = 1'b1;
                    busy_next     = 1'b0;
                    state_next    = IDLE;
                end else begin
                    baud_cnt_next = baud_cnt_reg + 1'b1;
                end
            end
            ABORT: begin
                // Both strobes together tell the shift register to clear the line.
                load_next      = 1'b1;
                shift_next     = 1'b1;
                busy_next      = 1'b0;
                baud_cnt_next  = '0;
                shift_cnt_next = '0;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign tx_busy    = busy_reg;
    assign tx_done    = done_reg;
    assign sr_load    = load_reg;
    assign sr_shift   = shift_reg;
    assign sr_din     = din_reg;
    assign parity_bit = parity_reg;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: even- and odd-parity instances driven in lockstep and
// compared every cycle against a timeline model built from frame-start arithmetic.
module tb_uart_tx_ctrl;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_abort;

    logic       busy_e, done_e, load_e, shift_e, par_e;
    logic [7:0] din_e;
    logic       busy_o, done_o, load_o, shift_o, par_o;
    logic [7:0] din_o;

    always #5 clk = ~clk;

    uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) dut_even (
        .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data), .tx_abort(tx_abort),
        .tx_busy(busy_e), .tx_done(done_e), .sr_load(load_e), .sr_shift(shift_e),
        .sr_din(din_e), .parity_bit(par_e)
    );

    uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b1)) dut_odd (
        .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data), .tx_abort(tx_abort),
        .tx_busy(busy_o), .tx_done(done_o), .sr_load(load_o), .sr_shift(shift_o),
        .sr_din(din_o), .parity_bit(par_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: mode 0 idle, 1 frame in flight since accept edge m_n, 2 abort strobe due.
    int         m_mode = 0;
    int         m_n    = 0;
    logic [7:0] m_din  = 8'h00;
    logic       m_par_e = 1'b0, m_par_o = 1'b0;
    logic       m_load = 1'b0, m_shift = 1'b0, m_done = 1'b0, m_busy = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_edge();
        int r;
        int m;
        if (!rst) begin
            m_mode = 0; m_din = 8'h00; m_par_e = 1'b0; m_par_o = 1'b0;
            m_load = 1'b0; m_shift = 1'b0; m_done = 1'b0; m_busy = 1'b0;
        end else begin
            case (m_mode)
                0: begin
                    m_load = 1'b0; m_shift = 1'b0; m_done = 1'b0; m_busy = 1'b0;
                    if (tx_start && !tx_abort) begin
                        m_din   = tx_data;
                        m_par_e = ^tx_data;
                        m_par_o = ~^tx_data;
                        m_mode  = 1;
                        m_n     = cyc;
                        $display("cycle %0d: frame accepted data=%02h", cyc, tx_data);
                    end
                end
                1: begin
                    r = cyc - m_n;
                    if (tx_abort) begin
                        m_load = 1'b0; m_shift = 1'b0; m_done = 1'b0;
                        m_busy = (r >= 2);
                        m_mode = 2;
                    end else begin
                        m = r - 1;
                        m_load  = (m == 0);
                        m_shift = (m > 0) && (m % CPB == 0) && (m / CPB <= 10);
                        m_done  = (m == 11 * CPB);
                        m_busy  = (m < 11 * CPB);
                        if (m_done) begin
                            m_mode = 0;
                            $display("cycle %0d: frame done data=%02h", cyc, m_din);
                        end
                    end
                end
                default: begin
                    m_load = 1'b1; m_shift = 1'b1; m_done = 1'b0; m_busy = 1'b0;
                    m_mode = 0;
                    $display("cycle %0d: frame aborted data=%02h", cyc, m_din);
                end
            endcase
        end
    endtask

    task automatic step(input logic s, input logic [7:0] d, input logic a, input logic r);
        @(negedge clk);
        tx_start = s; tx_data = d; tx_abort = a; rst = r;
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check("busy_e",  busy_e,  m_busy);
        check("done_e",  done_e,  m_done);
        check("load_e",  load_e,  m_load);
        check("shift_e", shift_e, m_shift);
        check("din_e",   din_e,   m_din);
        check("par_e",   par_e,   m_par_e);
        check("busy_o",  busy_o,  m_busy);
        check("done_o",  done_o,  m_done);
        check("load_o",  load_o,  m_load);
        check("shift_o", shift_o, m_shift);
        check("din_o",   din_o,   m_din);
        check("par_o",   par_o,   m_par_o);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    initial begin
        tx_start = 1'b0; tx_data = 8'h00; tx_abort = 1'b0; rst = 1'b0;

        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
        check("reset_busy", busy_e, 1'b0);
        check("reset_din", din_e, 8'h00);

        // Single frame, edge-accurate timing against the model.
        step(1'b1, 8'hA5, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("a5_load", load_e, 1'b1);
        check("a5_din", din_e, 8'hA5);
        check("a5_par_even", par_e, 1'b0);
        idle(50);

        // Parity on both instances for single-bit and two-bit payloads.
        step(1'b1, 8'h01, 1'b0, 1'b1);
        check("p01_odd", par_o, 1'b0);
        check("p01_even", par_e, 1'b1);
        idle(47);
        step(1'b1, 8'h03, 1'b0, 1'b1);
        check("p03_odd", par_o, 1'b1);
        idle(47);

        // Back-to-back with tx_start held; the second byte is presented from the done cycle on.
        step(1'b1, 8'h55, 1'b0, 1'b1);
        for (int i = 0; i < 45; i++) step(1'b1, 8'h55, 1'b0, 1'b1);
        check("b2b_done", done_e, 1'b1);
        step(1'b1, 8'hAA, 1'b0, 1'b1);
        step(1'b1, 8'hAA, 1'b0, 1'b1);
        check("b2b_load", load_e, 1'b1);
        check("b2b_din", din_e, 8'hAA);
        for (int i = 0; i < 3; i++) step(1'b1, 8'hAA, 1'b0, 1'b1);
        idle(50);

        // Start pulse while busy is dropped.
        step(1'b1, 8'h12, 1'b0, 1'b1);
        idle(19);
        step(1'b1, 8'hFF, 1'b0, 1'b1);
        idle(30);
        check("busy_rej_din", din_e, 8'h12);
        idle(10);

        // Abort mid-frame, then a clean frame.
        step(1'b1, 8'h3C, 1'b0, 1'b1);
        idle(14);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("abort_load", load_e, 1'b1);
        check("abort_shift", shift_e, 1'b1);
        check("abort_busy", busy_e, 1'b0);
        idle(5);
        step(1'b1, 8'hC3, 1'b0, 1'b1);
        idle(50);

        // Abort together with start in idle must not start a frame.
        step(1'b1, 8'h77, 1'b1, 1'b1);
        idle(3);

        // Reset mid-frame.
        step(1'b1, 8'h9E, 1'b0, 1'b1);
        idle(9);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("rst_mid_din", din_e, 8'h00);
        idle(50);

        // Randomized traffic with occasional aborts and resets.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 6) == 0, 8'($urandom), ($urandom % 40) == 0, ($urandom % 700) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
